// File: rtl/issue_scoreboard.sv
// Issue scoreboard between decode and execute: tracks destination registers of
// in-flight multi-cycle writers, stalls RAW/WAW hazards and caps outstanding writes.
module issue_scoreboard #(
  parameter int MAX_PENDING = 2,
  parameter bit TRACK_ALL   = 1'b0,
  localparam int CW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [4:0]    i_rs1_addr,
  input  logic [4:0]    i_rs2_addr,
  input  logic          i_uses_rs1,
  input  logic          i_uses_rs2,
  input  logic [4:0]    i_rd_addr,
  input  logic          i_is_load,
  input  logic          i_ex_ready,
  input  logic          i_flush,
  input  logic          i_wb_valid,
  input  logic [4:0]    i_wb_addr,
  output logic          o_issue,
  output logic          o_stall,
  output logic [31:0]   o_busy,
  output logic [CW-1:0] o_pending,
  output logic          o_wb_err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

  logic [31:0]   busy, busy_nxt;
  logic [31:0]   wb_mask, eff_busy;
  logic [CW-1:0] pending, pending_nxt, pending_eff;
  logic          wb_err;
  logic          retire_now, tracked, raw, waw, full, hazard, set_now;

  // A writeback landing this cycle is forwarded by the write-through regfile,
  // so its register no longer counts as a hazard.
  assign wb_mask  = i_wb_valid ? (32'd1 << i_wb_addr) : 32'd0;
  assign eff_busy = busy & ~wb_mask;

  assign retire_now  = i_wb_valid & busy[i_wb_addr];
  assign tracked     = (i_rd_addr != 5'd0) & (i_is_load | TRACK_ALL);
  assign raw         = (i_uses_rs1 & (i_rs1_addr != 5'd0) & eff_busy[i_rs1_addr]) |
                       (i_uses_rs2 & (i_rs2_addr != 5'd0) & eff_busy[i_rs2_addr]);
  assign waw         = (i_rd_addr != 5'd0) & eff_busy[i_rd_addr];
  assign pending_eff = pending - CW'(retire_now);
  assign full        = tracked & (pending_eff == MAX_CNT);
  assign hazard      = raw | waw | full;

  assign o_ready = ~hazard & i_ex_ready & ~i_flush;
  assign o_issue = i_valid & o_ready;
  assign o_stall = i_valid & hazard;
  assign set_now = o_issue & tracked;

  // Set is applied after clear so a same-register retire+issue stays busy.
  always_comb begin
    busy_nxt = busy;
    if (retire_now) busy_nxt[i_wb_addr] = 1'b0;
    if (set_now)    busy_nxt[i_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    pending_nxt = pending + CW'(set_now) - CW'(retire_now);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy    <= 32'd0;
      pending <= '0;
      wb_err  <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      pending <= pending_nxt;
      if (i_wb_valid && !retire_now) wb_err <= 1'b1;
    end
  end

  assign o_busy    = busy;
  assign o_pending = pending;
  assign o_wb_err  = wb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a behavioural model queues expected
// outputs per cycle; they are popped and compared as the DUT produces them.
module tb_issue_scoreboard;

  localparam int MAXP = 2;
  localparam int CW   = $clog2(MAXP + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [4:0]    i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0, i_wb_addr = '0;
  logic          i_uses_rs1 = 1'b0, i_uses_rs2 = 1'b0, i_is_load = 1'b0;
  logic          i_ex_ready = 1'b1, i_flush = 1'b0, i_wb_valid = 1'b0;
  logic          o_issue, o_stall, o_wb_err;
  logic [31:0]   o_busy;
  logic [CW-1:0] o_pending;

  issue_scoreboard #(.MAX_PENDING(MAXP), .TRACK_ALL(1'b0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2),
    .i_rd_addr(i_rd_addr), .i_is_load(i_is_load), .i_ex_ready(i_ex_ready),
    .i_flush(i_flush), .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr),
    .o_issue(o_issue), .o_stall(o_stall), .o_busy(o_busy),
    .o_pending(o_pending), .o_wb_err(o_wb_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  bit   [31:0] m_busy = '0;
  int          m_pend = 0;
  bit          m_err  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input logic [63:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_empty got=%h exp=none", got);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  function automatic logic [63:0] pack_state(bit [31:0] b, int p, bit e);
    return {31'd0, e, b[31:0]} | (64'(p) << 33);
  endfunction

  // One cycle: drive after the falling edge, check combinational outputs, then
  // check registered state just after the rising edge.
  task automatic cycle(input string tag, input bit v, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int rd, input bit ld,
                       input bit exr, input bit fl, input bit wbv, input int wba);
    bit [31:0] eff;
    bit raw, waw, trk, ret, full, haz, rdy, iss, stl;
    exp_t e;
    @(negedge i_clk);
    i_valid = v; i_rs1_addr = 5'(rs1); i_uses_rs1 = u1; i_rs2_addr = 5'(rs2);
    i_uses_rs2 = u2; i_rd_addr = 5'(rd); i_is_load = ld; i_ex_ready = exr;
    i_flush = fl; i_wb_valid = wbv; i_wb_addr = 5'(wba);

    eff = m_busy;
    if (wbv) eff[wba] = 1'b0;
    raw  = (u1 && rs1 != 0 && eff[rs1]) || (u2 && rs2 != 0 && eff[rs2]);
    waw  = (rd != 0) && eff[rd];
    trk  = (rd != 0) && ld;
    ret  = wbv && m_busy[wba];
    full = trk && ((m_pend - int'(ret)) == MAXP);
    haz  = raw || waw || full;
    rdy  = !haz && exr && !fl;
    iss  = v && rdy;
    stl  = v && haz;
    e.tag = {tag, "_comb"};
    e.exp = {61'd0, rdy, iss, stl};
    exp_q.push_back(e);
    #1;
    pop_check({61'd0, o_ready, o_issue, o_stall});

    if (ret) begin m_busy[wba] = 1'b0; m_pend--; end
    else if (wbv) m_err = 1'b1;
    if (iss && trk) begin m_busy[rd] = 1'b1; m_pend++; end

    @(posedge i_clk);
    e.tag = {tag, "_state"};
    e.exp = pack_state(m_busy, m_pend, m_err);
    exp_q.push_back(e);
    #1;
    pop_check(pack_state(o_busy, int'(o_pending), o_wb_err));
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_val("rst_busy", 64'(o_busy), 64'd0);
    check_val("rst_pending", 64'(o_pending), 64'd0);
    check_val("rst_err", 64'(o_wb_err), 64'd0);
    i_rst_n = 1'b1;

    // load x5, then dependent add x6 = x5 + x1, then same with bypassing writeback
    cycle("ld_x5",      1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    cycle("raw_stall",  1, 5, 1, 1, 1, 6, 0, 1, 0, 0, 0);
    check_val("raw_busy5", 64'(o_busy[5]), 64'd1);
    cycle("raw_bypass", 1, 5, 1, 1, 1, 6, 0, 1, 0, 1, 5);
    check_val("bypass_busy", 64'(o_busy), 64'd0);

    // pending cap: x1, x2, then x3 full, then x3 with retire of x1
    cycle("ld_x1",     1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cycle("ld_x2",     1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    cycle("full_x3",   1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    cycle("full_wb",   1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 1);
    check_val("full_busy", 64'(o_busy), 64'h0000_000C);
    check_val("full_pend", 64'(o_pending), 64'd2);

    // untracked writers
    cycle("ld_x0",     1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle("alu_x9",    1, 4, 1, 0, 0, 9, 0, 1, 0, 0, 0);

    // flush, then release
    cycle("flush",     1, 11, 1, 12, 1, 10, 0, 1, 1, 0, 0);
    cycle("unflush",   1, 11, 1, 12, 1, 10, 0, 1, 0, 0, 0);

    // WAW on x2, execute back-pressure
    cycle("waw_x2",    1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    cycle("ex_block",  1, 4, 1, 0, 0, 8, 0, 0, 0, 0, 0);

    // writeback to non-busy x7 and to x0
    cycle("wb_bad7",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7);
    idle("err_hold");
    check_val("err_sticky", 64'(o_wb_err), 64'd1);
    cycle("wb_x0",     0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    // async reset mid-operation while a consumer of x3 stalls
    cycle("pre_rst",   1, 3, 1, 0, 0, 12, 0, 1, 0, 0, 0);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(o_busy), 64'd0);
    check_val("arst_pend", 64'(o_pending), 64'd0);
    check_val("arst_err", 64'(o_wb_err), 64'd0);
    m_busy = '0; m_pend = 0; m_err = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cycle("post_rst",  1, 3, 1, 0, 0, 12, 0, 1, 0, 0, 0);
    cycle("late_wb",   0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 300; n++) begin
      int wa;
      bit wv;
      wv = ($urandom_range(0, 2) == 0);
      wa = $urandom_range(0, 7);
      if (wv && $urandom_range(0, 3) != 0 && m_busy != 0) begin
        for (int k = 0; k < 32; k++) if (m_busy[(wa + k) % 32]) begin wa = (wa + k) % 32; break; end
      end
      cycle("rnd", $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 5) != 0, $urandom_range(0, 9) == 0, wv, wa);
    end

    if (exp_q.size() != 0) check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller between decode and execute.
- Tracks destination registers of in-flight multi-cycle writers (loads, and optionally all writers) in a 32-entry busy vector.
- Stalls decoded instructions with RAW or WAW hazards, and enforces a cap on outstanding loads.
- Handshakes with decode upstream (valid/ready) and with execute downstream (ready); writeback retires entries.

Parameters:
- MAX_PENDING, 2: max outstanding tracked writes (1..31); counter width is clog2(MAX_PENDING+1).
- TRACK_ALL, 0: 0 = only loads mark rd busy; 1 = every instruction with rd!=0 marks rd busy.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  decoded instruction present.
- o_ready  out  1  scoreboard accepts instruction this cycle.
- i_rs1_addr  in  5  source 1 register.
- i_rs2_addr  in  5  source 2 register.
- i_uses_rs1  in  1  rs1 is read.
- i_uses_rs2  in  1  rs2 is read.
- i_rd_addr  in  5  destination register; 0 = none.
- i_is_load  in  1  instruction is a load.
- i_ex_ready  in  1  execute stage can accept.
- i_flush  in  1  redirect; suppress issue this cycle.
- i_wb_valid  in  1  writeback retiring a tracked write.
- i_wb_addr  in  5  register being retired.
- o_issue  out  1  instruction handed to execute this cycle.
- o_stall  out  1  i_valid held back by a hazard.
- o_busy  out  32  busy vector; bit 0 is always 0.
- o_pending  out  clog2(MAX_PENDING+1)  outstanding tracked-write count.
- o_wb_err  out  1  sticky: writeback retired a non-busy register.

Behaviour:
- Reset (i_rst_n low, asynchronous): o_busy=0, o_pending=0, o_wb_err=0. Combinational outputs follow from this state.
- eff_busy[r] = busy[r] & ~(i_wb_valid & i_wb_addr==r). A same-cycle writeback bypasses the hazard; the register file is write-through.
- raw = (i_uses_rs1 & rs1!=0 & eff_busy[rs1]) | (i_uses_rs2 & rs2!=0 & eff_busy[rs2]).
- waw = rd!=0 & eff_busy[rd].
- tracked = rd!=0 & (i_is_load | TRACK_ALL).
- full = tracked & (o_pending - retire_now) == MAX_PENDING, where retire_now = 1 when i_wb_valid hits a busy register.
- hazard = raw | waw | full.
- o_ready = ~hazard & i_ex_ready & ~i_flush.
- o_issue = i_valid & o_ready.
- o_stall = i_valid & hazard. Purely combinational; no latency added.
- Next state, on the rising edge:
  - busy[wb_addr] clears if retire_now.
  - busy[rd] sets if o_issue & tracked.
  - Set wins when both target the same register.
  - o_pending += (o_issue & tracked) - retire_now. Net 0 when both occur.
- Writeback to a non-busy register, or to x0: no state change; o_wb_err sets and holds until reset.
- i_flush: blocks issue for that cycle only. The busy vector and count are untouched, because outstanding loads still write back.
- The counter never exceeds MAX_PENDING and never underflows (guaranteed by the full and retire_now rules).
- Reset asserted mid-operation clears all state immediately. Writebacks arriving after reset are flagged via o_wb_err.

Test Plan:
- Load x5 issued, then dependent add x6=x5+x1 with i_wb_valid=0 -> o_stall=1, o_issue=0, o_busy[5]=1. Assert i_wb_valid, i_wb_addr=5 the same cycle -> o_issue=1; next cycle o_busy=0, o_pending=0.
- MAX_PENDING=2: loads to x1 and x2 issue back to back; load to x3 -> full, o_stall=1. Writeback x1 in that cycle -> load x3 issues; o_pending stays 2; o_busy has bits 2 and 3 set.
- Load x0 or non-load with TRACK_ALL=0 -> issues, o_busy unchanged, o_pending unchanged.
- i_flush=1 with a hazard-free i_valid=1 -> o_issue=0, o_ready=0, state unchanged. Next cycle with i_flush=0 -> o_issue=1.
- i_wb_valid with i_wb_addr=7 while busy[7]=0 -> o_wb_err=1 from next cycle on, o_pending unchanged; only reset clears o_wb_err.
- i_rst_n pulsed low with o_pending=2 -> o_busy=0 and o_pending=0 asynchronously; a stalled consumer issues on the first cycle after release.
